// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory bus arbiter: FSM state encoding,
// grant identifiers and default bus widths.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 28;
    localparam int DATA_W_DEF = 128;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the I-cache and D-cache requests.
// Optional macro MEM_ARB_ROUND_ROBIN_EN: on a tie, grant the side that did
// not win last time; otherwise the D-cache always wins a tie.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic ic_req,
    input  logic dc_req,
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  logic last_grant,
`endif
    output logic grant_valid,
    output logic grant_id
);

    // Pick a winner whenever at least one side is requesting
    always_comb begin
        grant_valid = ic_req | dc_req;
        grant_id    = GNT_I;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (ic_req && dc_req) begin
            grant_id = ~last_grant;
        end else if (dc_req) begin
            grant_id = GNT_D;
        end
`else
        if (dc_req) begin
            grant_id = GNT_D;
        end
`endif
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one external memory bus between the I-cache miss port and the
// D-cache miss/write-back port. One block transfer at a time; the grant is
// held until memory answers, then the winner gets its data and a one-cycle
// ready pulse, followed by a single DONE cycle so a requester that is still
// dropping its level request cannot be granted twice.
// Optional macro MEM_ARB_ROUND_ROBIN_EN enables alternating tie-break.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ic_read,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic [DATA_W-1:0] ic_rdata,
    output logic              ic_ready,
    input  logic              dc_read,
    input  logic              dc_write,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic [DATA_W-1:0] dc_rdata,
    output logic              dc_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    arb_state_t        state_reg, state_next;
    logic              mem_read_reg, mem_read_next;
    logic              mem_write_reg, mem_write_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
    logic [DATA_W-1:0] ic_rdata_reg, ic_rdata_next;
    logic [DATA_W-1:0] dc_rdata_reg, dc_rdata_next;
    logic              ic_ready_reg, ic_ready_next;
    logic              dc_ready_reg, dc_ready_next;
    logic              dc_req;
    logic              grant_valid;
    logic              grant_id;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic              last_grant_reg, last_grant_next;
`endif

    assign dc_req = dc_read | dc_write;

    mem_arb_pick u_pick (
        .ic_req      (ic_read),
        .dc_req      (dc_req),
`ifdef MEM_ARB_ROUND_ROBIN_EN
        .last_grant  (last_grant_reg),
`endif
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // Next state and next values of every registered output
    always_comb begin
        state_next     = state_reg;
        mem_read_next  = mem_read_reg;
        mem_write_next = mem_write_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        ic_rdata_next  = ic_rdata_reg;
        dc_rdata_next  = dc_rdata_reg;
        ic_ready_next  = 1'b0;
        dc_ready_next  = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_grant_next = last_grant_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (grant_valid) begin
                    if (grant_id == GNT_D) begin
                        state_next     = BUSY_D;
                        mem_addr_next  = dc_addr;
                        mem_wdata_next = dc_wdata;
                        // A write-back wins if the D side raises both strobes
                        mem_write_next = dc_write;
                        mem_read_next  = ~dc_write;
                    end else begin
                        state_next     = BUSY_I;
                        mem_addr_next  = ic_addr;
                        mem_write_next = 1'b0;
                        mem_read_next  = 1'b1;
                    end
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_grant_next = grant_id;
`endif
                end
            end
            BUSY_I: begin
                if (mem_ready) begin
                    state_next    = DONE;
                    mem_read_next = 1'b0;
                    ic_rdata_next = mem_rdata;
                    ic_ready_next = 1'b1;
                end
            end
            BUSY_D: begin
                if (mem_ready) begin
                    state_next     = DONE;
                    mem_read_next  = 1'b0;
                    mem_write_next = 1'b0;
                    // Write-backs return nothing, so keep the old block
                    if (mem_read_reg) begin
                        dc_rdata_next = mem_rdata;
                    end
                    dc_ready_next = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and output registers, cleared by synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            mem_read_reg  <= 1'b0;
            mem_write_reg <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            ic_rdata_reg  <= '0;
            dc_rdata_reg  <= '0;
            ic_ready_reg  <= 1'b0;
            dc_ready_reg  <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant_reg <= GNT_I;
`endif
        end else begin
            state_reg     <= state_next;
            mem_read_reg  <= mem_read_next;
            mem_write_reg <= mem_write_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            ic_rdata_reg  <= ic_rdata_next;
            dc_rdata_reg  <= dc_rdata_next;
            ic_ready_reg  <= ic_ready_next;
            dc_ready_reg  <= dc_ready_next;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant_reg <= last_grant_next;
`endif
        end
    end

    assign mem_read  = mem_read_reg;
    assign mem_write = mem_write_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign ic_rdata  = ic_rdata_reg;
    assign dc_rdata  = dc_rdata_reg;
    assign ic_ready  = ic_ready_reg;
    assign dc_ready  = dc_ready_reg;

    // The D-cache must never request a read and a write-back at once
    assert property (@(posedge clk) disable iff (!rst_n) !(dc_read && dc_write));

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: table of single/dual transfers,
// hand-written corner sequences, then random traffic against a
// transaction-level model of the bus protocol.
module tb_mem_bus_arbiter;

    localparam int AW = 28;
    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ic_read;
    logic [AW-1:0] ic_addr;
    logic [DW-1:0] ic_rdata;
    logic          ic_ready;
    logic          dc_read;
    logic          dc_write;
    logic [AW-1:0] dc_addr;
    logic [DW-1:0] dc_wdata;
    logic [DW-1:0] dc_rdata;
    logic          dc_ready;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ic_read   (ic_read),
        .ic_addr   (ic_addr),
        .ic_rdata  (ic_rdata),
        .ic_ready  (ic_ready),
        .dc_read   (dc_read),
        .dc_write  (dc_write),
        .dc_addr   (dc_addr),
        .dc_wdata  (dc_wdata),
        .dc_rdata  (dc_rdata),
        .dc_ready  (dc_ready),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    // Memory contents: each block address maps to a distinctive pattern
    function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
        return {4'hA, a, 4'h5, ~a, 4'hC, a ^ 28'h0F0F0F0, 4'h3, a + 28'd7};
    endfunction

    // ---------------- memory responder ----------------
    int            mem_lat    = 3;
    bit            fixed_en   = 1'b0;
    logic [DW-1:0] fixed_data = '0;
    bit            spurious   = 1'b0;
    logic [DW-1:0] spurious_data = {4{32'hDEADBEEF}};

    initial begin : responder
        int cnt;
        cnt       = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ready = 1'b0;
            if (spurious) begin
                spurious  = 1'b0;
                mem_ready = 1'b1;
                mem_rdata = spurious_data;
            end else if (mem_read || mem_write) begin
                cnt++;
                if (cnt == mem_lat + 1) begin
                    mem_ready = 1'b1;
                    mem_rdata = fixed_en ? fixed_data : data_of(mem_addr);
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // ---------------- transaction-level model ----------------
    typedef enum int {PH_FREE, PH_XFER, PH_COOL} phase_e;
    phase_e        ph = PH_FREE;
    bit            m_d;
    bit            m_wr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_ic_rdata;
    logic [DW-1:0] m_dc_rdata;
    bit            mr_last;
    logic [DW-1:0] mrd_last;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    bit            m_last_d;
`endif

    // Called once per cycle: inputs still hold what the DUT sampled at the
    // last edge, outputs show what it registered there.
    task automatic monitor();
        bit e_icr;
        bit e_dcr;
        bit any_req;
        e_icr   = 1'b0;
        e_dcr   = 1'b0;
        any_req = ic_read || dc_read || dc_write;
        if (!rst_n) begin
            ph         = PH_FREE;
            m_wr       = 1'b0;
            m_addr     = '0;
            m_wdata    = '0;
            m_ic_rdata = '0;
            m_dc_rdata = '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            m_last_d   = 1'b0;
`endif
        end else begin
            case (ph)
                PH_FREE: begin
                    if (any_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        if (ic_read && (dc_read || dc_write)) m_d = !m_last_d;
                        else m_d = dc_read || dc_write;
                        m_last_d = m_d;
`else
                        m_d = dc_read || dc_write;
`endif
                        ph = PH_XFER;
                        if (m_d) begin
                            m_wr    = dc_write;
                            m_addr  = dc_addr;
                            m_wdata = dc_wdata;
                        end else begin
                            m_wr   = 1'b0;
                            m_addr = ic_addr;
                        end
                    end
                end
                PH_XFER: begin
                    if (mr_last) begin
                        ph = PH_COOL;
                        if (m_d) begin
                            e_dcr = 1'b1;
                            if (!m_wr) m_dc_rdata = mrd_last;
                        end else begin
                            e_icr = 1'b1;
                            m_ic_rdata = mrd_last;
                        end
                        $display("xfer cycle=%0d side=%s op=%s addr=%h", cyc,
                                 m_d ? "D" : "I", m_wr ? "WR" : "RD", m_addr);
                    end
                end
                default: ph = PH_FREE;
            endcase
        end
        chk("mem_read", mem_read, (ph == PH_XFER) && !m_wr);
        chk("mem_write", mem_write, (ph == PH_XFER) && m_wr);
        chk("ic_ready", ic_ready, e_icr);
        chk("dc_ready", dc_ready, e_dcr);
        chk("ready_excl", ic_ready & dc_ready, 1'b0);
        chk("ic_rdata", ic_rdata, m_ic_rdata);
        chk("dc_rdata", dc_rdata, m_dc_rdata);
        if (!rst_n || ph == PH_XFER) chk("mem_addr", mem_addr, m_addr);
        if (!rst_n || (ph == PH_XFER && m_wr)) chk("mem_wdata", mem_wdata, m_wdata);
        mr_last  = mem_ready;
        mrd_last = mem_rdata;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        cyc++;
        monitor();
    endtask

    // Requesters drop their level request on seeing their ready pulse
    task automatic drop_on_ready();
        if (ic_ready) ic_read = 1'b0;
        if (dc_ready) begin
            dc_read  = 1'b0;
            dc_write = 1'b0;
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        string         name;
        bit            ic_rd;
        bit            dc_rd;
        bit            dc_wr;
        logic [AW-1:0] ic_a;
        logic [AW-1:0] dc_a;
        logic [DW-1:0] wd;
        int            lat;
        bit            fixed;
        bit            exp_first_d;
        int            exp_ready1;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int            rises;
        bit            seen;
        bit            got;
        bit            prev_strobe;
        logic [AW-1:0] fresh_a;

        rst_n    = 1'b0;
        ic_read  = 1'b0;
        ic_addr  = '0;
        dc_read  = 1'b0;
        dc_write = 1'b0;
        dc_addr  = '0;
        dc_wdata = '0;
        fixed_data = {16{8'hA5}};

        vecs[0] = '{"i_read", 1, 0, 0, 28'h0000040, 28'h0, 128'h0, 3, 1, 0, 5};
        vecs[1] = '{"d_read", 0, 1, 0, 28'h0, 28'h0000200, 128'h0, 1, 0, 1, 3};
        vecs[2] = '{"d_write", 0, 0, 1, 28'h0, 28'h0000100,
                    128'h0123456789ABCDEF0123456789ABCDEF, 4, 0, 1, 6};
`ifdef MEM_ARB_ROUND_ROBIN_EN
        vecs[3] = '{"both_read", 1, 1, 0, 28'h0000080, 28'h0000300, 128'h0, 2, 0, 0, 4};
        vecs[4] = '{"i_and_dwrite", 1, 0, 1, 28'h00000C0, 28'h0000140,
                    128'hFEDCBA98765432100011223344556677, 0, 0, 0, 2};
`else
        vecs[3] = '{"both_read", 1, 1, 0, 28'h0000080, 28'h0000300, 128'h0, 2, 0, 1, 4};
        vecs[4] = '{"i_and_dwrite", 1, 0, 1, 28'h00000C0, 28'h0000140,
                    128'hFEDCBA98765432100011223344556677, 0, 0, 1, 2};
`endif

        // Reset: every output must read zero
        repeat (3) tick();
        chk("reset.mem_read", mem_read, 1'b0);
        chk("reset.ic_rdata", ic_rdata, '0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            int            c0;
            int            first_strobe;
            int            second_strobe;
            int            first_ready;
            bit            first_side_d;
            bit            both;
            logic [AW-1:0] first_addr;
            mem_lat  = vecs[i].lat;
            fixed_en = vecs[i].fixed;
            ic_read  = vecs[i].ic_rd;
            ic_addr  = vecs[i].ic_a;
            dc_read  = vecs[i].dc_rd;
            dc_write = vecs[i].dc_wr;
            dc_addr  = vecs[i].dc_a;
            dc_wdata = vecs[i].wd;
            both     = vecs[i].ic_rd && (vecs[i].dc_rd || vecs[i].dc_wr);
            c0 = cyc;
            first_strobe  = -1;
            second_strobe = -1;
            first_ready   = -1;
            first_side_d  = 1'b0;
            first_addr    = '0;
            prev_strobe   = 1'b0;
            for (int t = 0; t < 24; t++) begin
                tick();
                if ((mem_read || mem_write) && !prev_strobe) begin
                    if (first_strobe < 0) begin
                        first_strobe = cyc - c0;
                        first_addr   = mem_addr;
                    end else if (second_strobe < 0) begin
                        second_strobe = cyc - c0;
                    end
                end
                if ((ic_ready || dc_ready) && first_ready < 0) begin
                    first_ready  = cyc - c0;
                    first_side_d = dc_ready;
                end
                prev_strobe = mem_read || mem_write;
                drop_on_ready();
            end
            chk($sformatf("%s.strobe_cycle", vecs[i].name), first_strobe, 1);
            chk($sformatf("%s.addr", vecs[i].name), first_addr,
                vecs[i].exp_first_d ? vecs[i].dc_a : vecs[i].ic_a);
            chk($sformatf("%s.ready_cycle", vecs[i].name), first_ready, vecs[i].exp_ready1);
            chk($sformatf("%s.winner", vecs[i].name), first_side_d, vecs[i].exp_first_d);
            if (both) chk($sformatf("%s.regrant_cycle", vecs[i].name), second_strobe, first_ready + 2);
            else chk($sformatf("%s.no_regrant", vecs[i].name), second_strobe, -1);
        end
        fixed_en = 1'b0;

        // Request held through the DONE cycle must not be granted twice
        mem_lat = 2;
        dc_read = 1'b1;
        dc_addr = 28'h0000480;
        rises = 0;
        seen  = 1'b0;
        prev_strobe = 1'b0;
        for (int t = 0; t < 20; t++) begin
            tick();
            if ((mem_read || mem_write) && !prev_strobe) rises++;
            prev_strobe = mem_read || mem_write;
            if (dc_ready) seen = 1'b1;
            else if (seen) dc_read = 1'b0;
        end
        chk("held.strobe_count", rises, 1);
        chk("held.dc_rdata", dc_rdata, data_of(28'h0000480));

        // Reset in the middle of an I transfer abandons it
        mem_lat = 10;
        ic_read = 1'b1;
        ic_addr = 28'h0000500;
        repeat (3) tick();
        chk("midrst.busy", mem_read, 1'b1);
        rst_n   = 1'b0;
        ic_read = 1'b0;
        tick();
        chk("midrst.mem_read", mem_read, 1'b0);
        chk("midrst.ic_ready", ic_ready, 1'b0);
        chk("midrst.ic_rdata", ic_rdata, '0);
        rst_n = 1'b1;
        mem_lat = 2;
        repeat (3) tick();
        fresh_a = 28'h0000600;
        ic_read = 1'b1;
        ic_addr = fresh_a;
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            tick();
            if (ic_ready) begin
                got = 1'b1;
                chk("fresh.ic_rdata", ic_rdata, data_of(fresh_a));
            end
            drop_on_ready();
        end
        chk("fresh.serviced", got, 1'b1);
        repeat (3) tick();

        // Spurious mem_ready while idle is ignored
        spurious = 1'b1;
        for (int t = 0; t < 4; t++) begin
            tick();
            chk("spur.ic_ready", ic_ready, 1'b0);
            chk("spur.dc_ready", dc_ready, 1'b0);
            chk("spur.strobe", mem_read | mem_write, 1'b0);
            chk("spur.ic_rdata", ic_rdata, data_of(fresh_a));
        end

        // Random traffic checked cycle by cycle against the model
        prev_strobe = 1'b0;
        for (int t = 0; t < 400; t++) begin
            tick();
            if ((mem_read || mem_write) && !prev_strobe) mem_lat = $urandom_range(1, 5);
            prev_strobe = mem_read || mem_write;
            drop_on_ready();
            if (!ic_read && $urandom_range(0, 3) == 0) begin
                ic_read = 1'b1;
                ic_addr = AW'($urandom());
            end
            if (!dc_read && !dc_write && $urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 1) == 1) dc_write = 1'b1;
                else dc_read = 1'b1;
                dc_addr  = AW'($urandom());
                dc_wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
        end
        for (int t = 0; t < 40; t++) begin
            tick();
            drop_on_ready();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
